thirty_two_bits_full_adder: RTL and testbench



---
 rtl/mips_pkg.sv | 8 +
 rtl/full_adder_1bit.sv | 19 +
 rtl/thirty_two_bits_full_adder.sv | 59 +++++
 tb/tb_thirty_two_bits_full_adder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared word-size definitions for the MIPS integer datapath.
package mips_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full-adder cell; chained to form the ripple-carry word adder.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half;

   // Propagate term is shared by the sum bit and the carry-propagate path.
   always_comb begin
      half = a ^ b;
      s    = half ^ cin;
      cout = (a & b) | (cin & half);
   end

endmodule

// File: rtl/thirty_two_bits_full_adder.sv
// Registered 32-bit ripple-carry adder with carry-in, carry-out and signed
// overflow. The combinational core is a chain of 1-bit cells; one register
// stage captures the result together with a valid strobe.
module thirty_two_bits_full_adder
   import mips_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   input  word_t a,
   input  word_t b,
   input  logic  c0,
   output logic  out_valid,
   output word_t s,
   output logic  cout,
   output logic  ovf
);

   // carry[i] is the carry into bit i; carry[WORD_W] is the carry out.
   logic [WORD_W:0] carry;
   word_t           s_c;
   logic            cout_c;
   logic            ovf_c;

   assign carry[0] = c0;

   for (genvar i = 0; i < WORD_W; i++) begin : g_bit
      full_adder_1bit u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry[i]),
         .s    (s_c[i]),
         .cout (carry[i+1])
      );
   end

   // Signed overflow occurs when the carry into the sign bit differs from
   // the carry out of it.
   assign cout_c = carry[WORD_W];
   assign ovf_c  = carry[WORD_W-1] ^ carry[WORD_W];

   // Output stage: capture on valid, hold data otherwise; reset clears all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         s         <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            s    <= s_c;
            cout <= cout_c;
            ovf  <= ovf_c;
         end
      end
   end

endmodule

// File: tb/tb_thirty_two_bits_full_adder.sv
// Self-checking bench for thirty_two_bits_full_adder using a result scoreboard.
module tb_thirty_two_bits_full_adder;

   typedef struct packed {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        c0;
   logic        out_valid;
   logic [31:0] s;
   logic        cout;
   logic        ovf;

   exp_t sb[$];
   exp_t last_exp;
   int   n_checks;
   int   n_fail;

   thirty_two_bits_full_adder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c0        (c0),
      .out_valid (out_valid),
      .s         (s),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: 33-bit arithmetic sum; overflow from operand/result signs.
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
      logic [32:0] sum;
      exp_t e;
      sum    = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      e.s    = sum[31:0];
      e.cout = sum[32];
      e.ovf  = (x[31] == y[31]) && (sum[31] != x[31]);
      return e;
   endfunction

   function automatic exp_t mk(input logic [31:0] sv, input logic cv, input logic ov);
      exp_t e;
      e.s = sv; e.cout = cv; e.ovf = ov;
      return e;
   endfunction

   task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic cv, input exp_t e);
      a        = av;
      b        = bv;
      c0       = cv;
      in_valid = 1'b1;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      // Load a nonzero result, then assert reset between edges.
      drive(32'hDEADBEEF, 32'h12345678, 1'b1, model(32'hDEADBEEF, 32'h12345678, 1'b1));
      @(posedge clk); #1;
      sb.delete();
      a = $urandom; b = $urandom; c0 = 1'($urandom); in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, cout, ovf, s} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_async: got v=%b s=%h cout=%b ovf=%b, want all zero", out_valid, s, cout, ovf);
      end
      @(posedge clk); #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
   endtask

   task automatic test_carry_cases();
      exp_t e;
      logic [31:0] ta[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] tb[2] = '{32'hFFFFFFFF, 32'hFFFFFAFF};
      logic        tc[2] = '{1'b0, 1'b1};
      exp_t        te[2];
      te[0] = mk(32'hFFFFFFFE, 1'b1, 1'b0);
      te[1] = mk(32'hFFFFFAFF, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive(ta[i], tb[i], tc[i], te[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({out_valid, s, cout, ovf} !== {1'b1, e.s, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL carry_case%0d: got v=%b s=%h cout=%b ovf=%b, want v=1 s=%h cout=%b ovf=%b",
                     i, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
         end
         last_exp = e;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] ta[7] = '{32'd1092657, 32'd2526234, 32'd90221, 32'd12, 32'd15, 32'd9, 32'd345678};
      logic [31:0] tb[7] = '{32'd1534, 32'd1274323, 32'd8821000, 32'd10, 32'd15, 32'd9, 32'd987654};
      logic        tc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ts[7] = '{32'd1094191, 32'd3800557, 32'd8911221, 32'd22, 32'd31, 32'd18, 32'd1333332};
      // One operation per cycle: the next operand set is driven right after
      // the previous result is checked, before the following edge.
      for (int i = 0; i < 7; i++) begin
         drive(ta[i], tb[i], tc[i], mk(ts[i], 1'b0, 1'b0));
         @(posedge clk); #1;
         e = sb.pop_front();
         n_checks++;
         if ({out_valid, s, cout, ovf} !== {1'b1, e.s, e.cout, e.ovf}) begin
            n_fail++;
            $display("FAIL stream%0d: got v=%b s=%0d cout=%b ovf=%b, want v=1 s=%0d cout=%b ovf=%b",
                     i, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
         end
         last_exp = e;
      end
      // Random operands back to back, checked against the arithmetic model.
      for (int i = 0; i < 10; i++) begin
         logic [31:0] ra, rb;
         logic        rc;
         ra = $urandom; rb = $urandom; rc = 1'($urandom);
         drive(ra, rb, rc, model(ra, rb, rc));
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL random%0d: scoreboard empty, got v=%b, want an entry", i, out_valid);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if ({out_valid, s, cout, ovf} !== {1'b1, e.s, e.cout, e.ovf}) begin
               n_fail++;
               $display("FAIL random%0d: got v=%b s=%h cout=%b ovf=%b, want v=1 s=%h cout=%b ovf=%b",
                        i, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
            end
            last_exp = e;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_overflow();
      exp_t e;
      drive(32'h7FFFFFFF, 32'h00000001, 1'b0, mk(32'h80000000, 1'b0, 1'b1));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({out_valid, s, cout, ovf} !== {1'b1, e.s, e.cout, e.ovf}) begin
         n_fail++;
         $display("FAIL signed_ovf: got v=%b s=%h cout=%b ovf=%b, want v=1 s=%h cout=%b ovf=%b",
                  out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
      end
      // Negative overflow: 0x80000000 + 0xFFFFFFFF wraps to positive.
      drive(32'h80000000, 32'hFFFFFFFF, 1'b0, mk(32'h7FFFFFFF, 1'b1, 1'b1));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({out_valid, s, cout, ovf} !== {1'b1, e.s, e.cout, e.ovf}) begin
         n_fail++;
         $display("FAIL neg_ovf: got v=%b s=%h cout=%b ovf=%b, want v=1 s=%h cout=%b ovf=%b",
                  out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
      end
      last_exp = e;
      in_valid = 1'b0;
   endtask

   task automatic test_idle();
      exp_t e;
      drive(32'h0000_1111, 32'h0000_2222, 1'b0, mk(32'h0000_3333, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      last_exp = e;
      // Inputs change but are not qualified; the held result must not move.
      in_valid = 1'b0;
      a = 32'hFFFF_FFFF; b = 32'h0000_0005; c0 = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_valid: got out_valid=%b, want 0", out_valid);
      end
      n_checks++;
      if ({s, cout, ovf} !== {last_exp.s, last_exp.cout, last_exp.ovf}) begin
         n_fail++;
         $display("FAIL idle_hold: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
                  s, cout, ovf, last_exp.s, last_exp.cout, last_exp.ovf);
      end
   endtask

   task automatic test_reset_mid_stream();
      exp_t e;
      drive(32'hAAAA_0000, 32'h5555_0000, 1'b1, model(32'hAAAA_0000, 32'h5555_0000, 1'b1));
      @(posedge clk); #1;
      e = sb.pop_front();
      // Next operation is in flight when reset hits; it must be discarded.
      drive(32'h1234_0000, 32'h0000_5678, 1'b0, model(32'h1234_0000, 32'h0000_5678, 1'b0));
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      n_checks++;
      if ({out_valid, cout, ovf, s} !== 35'd0) begin
         n_fail++;
         $display("FAIL midreset_clear: got v=%b s=%h cout=%b ovf=%b, want all zero", out_valid, s, cout, ovf);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, cout, ovf, s} !== 35'd0) begin
         n_fail++;
         $display("FAIL midreset_held: got v=%b s=%h cout=%b ovf=%b, want all zero", out_valid, s, cout, ovf);
      end
      rst_n = 1'b1;
      drive(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({out_valid, s, cout, ovf} !== {1'b1, e.s, e.cout, e.ovf}) begin
         n_fail++;
         $display("FAIL after_reset: got v=%b s=%h cout=%b ovf=%b, want v=1 s=%h cout=%b ovf=%b",
                  out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_idle: got out_valid=%b, want 0", out_valid);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      c0       = 1'b0;
      last_exp = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      test_reset();
      test_carry_cases();
      test_back_to_back();
      test_overflow();
      test_idle();
      test_reset_mid_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
